q4_stimulus_sequencer: RTL and testbench

- Upstream stimulus stage for the Q4 combinational test circuit.
- Drives the circuit's 8-bit input bus through a complete vector sweep, either a binary count or an LFSR sequence.
- Samples the circuit's single meaningful output bit (bit 6) once per vector.
- Compresses the responses into a ones count and a 16-bit MISR signature for pass/fail comparison.

---
 rtl/q4_stimulus_sequencer_pkg.sv | 26 ++
 rtl/q4_stimulus_sequencer_if.sv | 25 ++
 rtl/q4_misr16.sv | 30 +++
 rtl/q4_stimulus_sequencer.sv | 113 +++++++++++
 tb/tb_q4_stimulus_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/q4_stimulus_sequencer_pkg.sv
// Shared types and constants for the Q4 stimulus sequencer and its signature stages.
// Holds the LFSR/MISR tap masks, the sweep lengths and the next-state helpers for both.
package q4_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   localparam logic [7:0]  LFSR_TAPS      = 8'hB8;
   localparam logic [15:0] MISR_TAPS      = 16'hB400;
   localparam logic [8:0]  SWEEP_LEN_BIN  = 9'd256;
   localparam logic [8:0]  SWEEP_LEN_LFSR = 9'd255;

   // x^8+x^6+x^5+x^4+1, shift left, XOR of the tapped bits enters bit 0
   function automatic logic [7:0] lfsr_next(input logic [7:0] c);
      return {c[6:0], ^(c & LFSR_TAPS)};
   endfunction

   function automatic logic [15:0] misr_next(input logic [15:0] s, input logic d);
      return {s[14:0], (^(s & MISR_TAPS)) ^ d};
   endfunction

endpackage

// File: rtl/q4_stimulus_sequencer_if.sv
// Control, vector and result bundle between the sequencer and its driver.
// The sequencer connects through the slave modport.
interface q4_stimulus_sequencer_if #(
   parameter int W = 8
) ();
   logic         start;
   logic         mode;
   logic         pause;
   logic         resp_bit;
   logic [W-1:0] cct_input;
   logic         busy;
   logic         done;
   logic [8:0]   ones_count;
   logic [15:0]  signature;

   modport master (
      output start, mode, pause, resp_bit,
      input  cct_input, busy, done, ones_count, signature
   );

   modport slave (
      input  start, mode, pause, resp_bit,
      output cct_input, busy, done, ones_count, signature
   );
endinterface

// File: rtl/q4_misr16.sv
// 16-bit single-input MISR used to compress one response bit per enabled cycle.
// Load takes priority over enable so a new sweep always starts from the seed.
module q4_misr16
   import q4_seq_pkg::*;
#(
   parameter logic [15:0] RESET_VAL = 16'hFFFF
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        load,
   input  logic        en,
   input  logic        din,
   input  logic [15:0] seed,
   output logic [15:0] sig
);
   logic [15:0] r_sig;

   // Signature register: seed on load, shift in the response on enable
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_sig <= RESET_VAL;
      end else if (load) begin
         r_sig <= seed;
      end else if (en) begin
         r_sig <= misr_next(r_sig, din);
      end
   end

   assign sig = r_sig;
endmodule

// File: rtl/q4_stimulus_sequencer.sv
// Drives the Q4 test circuit through a full binary or LFSR vector sweep and
// compresses its bit-6 response into a ones count and a MISR signature.
module q4_stimulus_sequencer
   import q4_seq_pkg::*;
#(
   parameter int          W         = 8,
   parameter logic [W-1:0] LFSR_SEED = 8'h01,
   parameter logic [15:0] SIG_SEED  = 16'hFFFF
) (
   input logic                    clk,
   input logic                    clear,
   q4_stimulus_sequencer_if.slave bus
);
   seq_state_e   r_state;
   seq_state_e   w_state_nxt;
   logic [W-1:0] r_vec;
   logic [8:0]   r_cnt;
   logic [8:0]   r_ones;
   logic         r_mode;
   logic         w_load;
   logic         w_step;
   logic         w_last;
   logic [8:0]   w_term;
   logic [15:0]  w_sig;

   // Counter value at the edge that samples the final vector of the sweep
   assign w_term = r_mode ? (SWEEP_LEN_LFSR - 9'd1) : (SWEEP_LEN_BIN - 9'd1);
   assign w_step = (r_state == ST_RUN) && !bus.pause;
   assign w_last = w_step && (r_cnt == w_term);

   // Next-state decode; start is honoured only from IDLE or DONE
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_RUN: begin
            if (bus.pause) begin
               w_state_nxt = ST_PAUSE;
            end else if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (!bus.pause) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_PAUSE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Vector generator, vector counter and ones counter; the last vector is held
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_vec  <= {W{1'b0}};
         r_cnt  <= 9'd0;
         r_ones <= 9'd0;
         r_mode <= 1'b0;
      end else if (w_load) begin
         r_vec  <= bus.mode ? LFSR_SEED : {W{1'b0}};
         r_cnt  <= 9'd0;
         r_ones <= 9'd0;
         r_mode <= bus.mode;
      end else if (w_step) begin
         r_ones <= r_ones + {8'd0, bus.resp_bit};
         if (!w_last) begin
            r_vec <= r_mode ? lfsr_next(r_vec) : (r_vec + {{(W-1){1'b0}}, 1'b1});
            r_cnt <= r_cnt + 9'd1;
         end
      end
   end

   q4_misr16 #(
      .RESET_VAL(SIG_SEED)
   ) u_misr (
      .clk  (clk),
      .clear(clear),
      .load (w_load),
      .en   (w_step),
      .din  (bus.resp_bit),
      .seed (SIG_SEED),
      .sig  (w_sig)
   );

   assign bus.cct_input  = r_vec;
   assign bus.busy       = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   assign bus.done       = (r_state == ST_DONE);
   assign bus.ones_count = r_ones;
   assign bus.signature  = w_sig;
endmodule

// File: tb/tb_q4_stimulus_sequencer.sv
// Bench for q4_stimulus_sequencer: a stand-in combinational Q4 circuit feeds resp_bit,
// and each sweep is compared against a list-based reference of vectors, ones and MISR.
module tb_q4_stimulus_sequencer;
   logic clk = 1'b0;
   logic clear;
   always #5 clk = ~clk;

   q4_stimulus_sequencer_if #(.W(8)) bus ();

   q4_stimulus_sequencer #(
      .W(8), .LFSR_SEED(8'h01), .SIG_SEED(16'hFFFF)
   ) u_dut (
      .clk  (clk),
      .clear(clear),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   int resp_sel = 0;
   logic [255:0] rand_tbl = '0;

   // Stand-in Q4 bit 6: true for low nibble 9..15 (112 of 256 vectors, 0 for vector 0)
   function automatic logic resp_of(input int sel, input logic [7:0] v, input logic [255:0] tbl);
      case (sel)
         0:       return (v[3:0] > 4'd8);
         1:       return 1'b1;
         2:       return 1'b0;
         default: return tbl[v];
      endcase
   endfunction

   always_comb bus.resp_bit = resp_of(resp_sel, bus.cct_input, rand_tbl);

   logic [7:0]  exp_q[$];
   logic [7:0]  obs_q[$];
   int          exp_ones;
   logic [15:0] exp_sig;

   task automatic model_sweep(input logic m);
      int   v;
      logic r;
      exp_q.delete();
      exp_ones = 0;
      exp_sig  = 16'hFFFF;
      if (m == 1'b0) begin
         for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
      end else begin
         v = 1;
         for (int i = 0; i < 255; i++) begin
            exp_q.push_back(8'(v));
            v = ((v * 2) % 256) + (((v >> 7) + (v >> 5) + (v >> 4) + (v >> 3)) % 2);
         end
      end
      foreach (exp_q[i]) begin
         r = resp_of(resp_sel, exp_q[i], rand_tbl);
         exp_ones += int'(r);
         exp_sig = {exp_sig[14:0], exp_sig[15] ^ exp_sig[13] ^ exp_sig[12] ^ exp_sig[10] ^ r};
      end
   endtask

   function automatic int vec_diff();
      int d = (obs_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         if (obs_q[i] !== exp_q[i]) d++;
      return d;
   endfunction

   // Starts a sweep, records the vector presented before every edge, optionally pauses
   task automatic run_sweep(input logic m, input int pause_vec, input int pause_len,
                            input bit inject, output int cycles, output int pause_err);
      logic [8:0]  snap_ones;
      logic [15:0] snap_sig;
      bit          paused = 1'b0;
      obs_q.delete();
      cycles    = 0;
      pause_err = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.mode = m; bus.pause = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      while (bus.done !== 1'b1 && cycles < 2000) begin
         bus.start = 1'b0;
         if (!paused && pause_vec >= 0 && bus.cct_input == 8'(pause_vec)) begin
            paused    = 1'b1;
            snap_ones = bus.ones_count;
            snap_sig  = bus.signature;
            bus.pause = 1'b1;
            for (int k = 0; k < pause_len; k++) begin
               @(negedge clk); cycles++;
               if (bus.cct_input !== 8'(pause_vec) || bus.busy !== 1'b1 ||
                   bus.ones_count !== snap_ones || bus.signature !== snap_sig) pause_err++;
            end
            bus.pause = 1'b0;
            @(negedge clk); cycles++;
            if (bus.cct_input !== 8'(pause_vec) || bus.ones_count !== snap_ones) pause_err++;
         end
         obs_q.push_back(bus.cct_input);
         bus.start = inject && (obs_q.size() == 50);
         if (inject && obs_q.size() == 60) bus.mode = ~m;
         @(negedge clk); cycles++;
      end
      bus.start = 1'b0;
      bus.mode  = m;
   endtask

   task automatic test_reset();
      clear = 1'b0; bus.start = 1'b0; bus.mode = 1'b0; bus.pause = 1'b0;
      #12;
      total++;
      if (bus.cct_input !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.ones_count !== 9'd0 || bus.signature !== 16'hFFFF) begin
         bad++;
         $display("FAIL reset_state: cct=%h busy=%b done=%b ones=%0d sig=%h want 00/0/0/0/ffff",
                  bus.cct_input, bus.busy, bus.done, bus.ones_count, bus.signature);
      end
      @(negedge clk); clear = 1'b1;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (40) @(negedge clk);
      total++;
      if (bus.cct_input !== 8'd40 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_prerun: cct=%h busy=%b want 28/1", bus.cct_input, bus.busy);
      end
      #2 clear = 1'b0;
      #1;
      total++;
      if (bus.cct_input !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.ones_count !== 9'd0 || bus.signature !== 16'hFFFF) begin
         bad++;
         $display("FAIL reset_async: cct=%h busy=%b done=%b ones=%0d sig=%h want 00/0/0/0/ffff",
                  bus.cct_input, bus.busy, bus.done, bus.ones_count, bus.signature);
      end
      @(negedge clk); clear = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cct_input !== 8'h00) begin
         bad++;
         $display("FAIL reset_idle: busy=%b done=%b cct=%h want 0/0/00", bus.busy, bus.done, bus.cct_input);
      end
   endtask

   task automatic test_mode0_circuit();
      int cyc, perr;
      resp_sel = 0;
      model_sweep(1'b0);
      run_sweep(1'b0, -1, 0, 1'b0, cyc, perr);
      total++;
      if (cyc !== 256 || bus.done !== 1'b1) begin
         bad++; $display("FAIL m0_cycles: got %0d done=%b want 256/1", cyc, bus.done);
      end
      total++;
      if (bus.ones_count !== 9'd112 || exp_ones !== 112) begin
         bad++; $display("FAIL m0_ones: got %0d model %0d want 112", bus.ones_count, exp_ones);
      end
      total++;
      if (bus.signature !== exp_sig) begin
         bad++; $display("FAIL m0_sig: got %h want %h", bus.signature, exp_sig);
      end
      total++;
      if (vec_diff() != 0 || bus.cct_input !== 8'hFF) begin
         bad++; $display("FAIL m0_vectors: diffs=%0d last=%h want 0/ff", vec_diff(), bus.cct_input);
      end
      repeat (3) @(negedge clk);
      total++;
      if (bus.done !== 1'b1 || bus.cct_input !== 8'hFF || bus.ones_count !== 9'd112) begin
         bad++; $display("FAIL m0_hold: done=%b cct=%h ones=%0d want 1/ff/112",
                         bus.done, bus.cct_input, bus.ones_count);
      end
   endtask

   task automatic test_mode1_circuit();
      int cyc, perr, dup;
      bit seen [256];
      resp_sel = 0;
      model_sweep(1'b1);
      run_sweep(1'b1, -1, 0, 1'b0, cyc, perr);
      dup = 0;
      foreach (seen[i]) seen[i] = 1'b0;
      foreach (obs_q[i]) begin
         if (seen[obs_q[i]] || obs_q[i] == 8'h00) dup++;
         seen[obs_q[i]] = 1'b1;
      end
      total++;
      if (obs_q.size() != 255 || dup != 0 || obs_q[0] !== 8'h01) begin
         bad++; $display("FAIL m1_distinct: n=%0d dup=%0d first=%h want 255/0/01",
                         obs_q.size(), dup, obs_q[0]);
      end
      total++;
      if (cyc !== 255 || bus.done !== 1'b1) begin
         bad++; $display("FAIL m1_cycles: got %0d done=%b want 255/1", cyc, bus.done);
      end
      total++;
      if (bus.ones_count !== 9'd112 || bus.signature !== exp_sig) begin
         bad++; $display("FAIL m1_result: ones=%0d sig=%h want 112/%h", bus.ones_count, bus.signature, exp_sig);
      end
      total++;
      if (vec_diff() != 0 || bus.cct_input !== exp_q[254]) begin
         bad++; $display("FAIL m1_vectors: diffs=%0d last=%h want 0/%h", vec_diff(), bus.cct_input, exp_q[254]);
      end
   endtask

   task automatic test_tied();
      int cyc, perr;
      for (int s = 1; s <= 2; s++) begin
         resp_sel = s;
         model_sweep(1'b0);
         run_sweep(1'b0, -1, 0, 1'b0, cyc, perr);
         total++;
         if (bus.ones_count !== ((s == 1) ? 9'd256 : 9'd0) || bus.signature !== exp_sig) begin
            bad++; $display("FAIL tied%0d: ones=%0d sig=%h want %0d/%h", s, bus.ones_count,
                            bus.signature, (s == 1) ? 256 : 0, exp_sig);
         end
      end
   endtask

   task automatic test_pause();
      int cyc, perr;
      resp_sel = 0;
      model_sweep(1'b0);
      run_sweep(1'b0, 32'h20, 10, 1'b1, cyc, perr);
      total++;
      if (perr != 0) begin
         bad++; $display("FAIL pause_freeze: violations=%0d want 0", perr);
      end
      total++;
      if (cyc !== 267 || bus.ones_count !== 9'd112 || bus.signature !== exp_sig) begin
         bad++; $display("FAIL pause_total: cycles=%0d ones=%0d sig=%h want 267/112/%h",
                         cyc, bus.ones_count, bus.signature, exp_sig);
      end
   endtask

   task automatic test_restart();
      @(negedge clk); bus.start = 1'b1; bus.mode = 1'b0;
      @(negedge clk); bus.start = 1'b0;
      total++;
      if (bus.cct_input !== 8'h00 || bus.ones_count !== 9'd0 || bus.signature !== 16'hFFFF ||
          bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL restart: cct=%h ones=%0d sig=%h done=%b busy=%b want 00/0/ffff/0/1",
                         bus.cct_input, bus.ones_count, bus.signature, bus.done, bus.busy);
      end
      #2 clear = 1'b0;
      @(negedge clk); clear = 1'b1;
      @(negedge clk); bus.start = 1'b1; bus.pause = 1'b1; bus.mode = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b1 || bus.cct_input !== 8'h01 || bus.ones_count !== 9'd0 ||
          bus.signature !== 16'hFFFF) begin
         bad++; $display("FAIL start_pause: busy=%b cct=%h ones=%0d sig=%h want 1/01/0/ffff",
                         bus.busy, bus.cct_input, bus.ones_count, bus.signature);
      end
      bus.pause = 1'b0;
      #2 clear = 1'b0;
      @(negedge clk); clear = 1'b1;
   endtask

   task automatic test_random();
      int cyc, perr, pidx, plen;
      logic m;
      for (int it = 0; it < 4; it++) begin
         rand_tbl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         resp_sel = 3;
         m    = 1'($urandom_range(0, 1));
         model_sweep(m);
         pidx = $urandom_range(1, 200);
         plen = $urandom_range(1, 6);
         run_sweep(m, int'(exp_q[pidx]), plen, 1'b1, cyc, perr);
         total++;
         if (cyc !== exp_q.size() + plen + 1 || perr != 0 || vec_diff() != 0 ||
             bus.ones_count !== 9'(exp_ones) || bus.signature !== exp_sig) begin
            bad++; $display("FAIL rand%0d: m=%b cyc=%0d/%0d perr=%0d vd=%0d ones=%0d/%0d sig=%h/%h",
                            it, m, cyc, exp_q.size() + plen + 1, perr, vec_diff(),
                            bus.ones_count, exp_ones, bus.signature, exp_sig);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mode0_circuit();
      test_restart();
      test_mode1_circuit();
      test_tied();
      test_pause();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
